dm_scan_ctrl: RTL

Self-test initiator for the data memory: drives the memory's address, write-data-select and write-enable inputs, walks every word through four write/read-back passes, and compares read data against the expected pattern. Sits in front of `memory` on the `clk_dm` domain and replaces the hand-written stimulus sequence with a repeatable built-in check. It reports completion, pass/fail, error count and the first failing location.

---
 rtl/dm_scan_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dm_scan_ctrl.sv
// Built-in self-test sequencer for the data memory on the clk_dm domain.
// Walks every word through four rotated-pattern write/read-back passes and records mismatches.
module dm_scan_ctrl #(
    parameter logic [5:0]  ADDR_LO = 6'd0,
    parameter logic [5:0]  ADDR_HI = 6'd63,
    parameter logic [31:0] PAT0    = 32'h0000_0000,
    parameter logic [31:0] PAT1    = 32'hFFFF_FFFF,
    parameter logic [31:0] PAT2    = 32'h5555_5555,
    parameter logic [31:0] PAT3    = 32'hAAAA_AAAA
) (
    input  logic        clk_dm,
    input  logic        rst_dm,
    input  logic        start,
    output logic [7:2]  DM_Addr,
    output logic [1:0]  MW_Data_s,
    output logic        Mem_Write,
    input  logic [31:0] M_R_Data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [8:0]  err_cnt,
    output logic [5:0]  first_err_addr,
    output logic [1:0]  first_err_pass,
    output logic [1:0]  state_dbg
);

    // start is a level request, honoured only in IDLE; busy/done report progress and
    // results stay stable from done until the next accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_d;
    logic [5:0]  addr, addr_d;
    logic [1:0]  pidx, pidx_d;
    logic [8:0]  errs, errs_d;
    logic [5:0]  fe_addr, fe_addr_d;
    logic [1:0]  fe_pass, fe_pass_d;
    logic        seen, seen_d;
    logic        pass_q, pass_d;
    logic [1:0]  sel;
    logic [31:0] exp_data;
    logic        miss;

    // Rotating the pattern by the low address bits makes neighbouring words differ in every pass.
    assign sel = pidx + addr[1:0];

    always_comb begin
        exp_data = PAT0;
        unique case (sel)
            2'd0: exp_data = PAT0;
            2'd1: exp_data = PAT1;
            2'd2: exp_data = PAT2;
            2'd3: exp_data = PAT3;
            default: exp_data = PAT0;
        endcase
    end

    assign miss = (M_R_Data != exp_data);

    always_ff @(posedge clk_dm) begin
        if (rst_dm) begin
            state   <= IDLE;
            addr    <= 6'd0;
            pidx    <= 2'd0;
            errs    <= 9'd0;
            fe_addr <= 6'd0;
            fe_pass <= 2'd0;
            seen    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state   <= state_d;
            addr    <= addr_d;
            pidx    <= pidx_d;
            errs    <= errs_d;
            fe_addr <= fe_addr_d;
            fe_pass <= fe_pass_d;
            seen    <= seen_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d   = state;
        addr_d    = addr;
        pidx_d    = pidx;
        errs_d    = errs;
        fe_addr_d = fe_addr;
        fe_pass_d = fe_pass;
        seen_d    = seen;
        pass_d    = pass_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d   = WR;
                    addr_d    = ADDR_LO;
                    pidx_d    = 2'd0;
                    errs_d    = 9'd0;
                    fe_addr_d = 6'd0;
                    fe_pass_d = 2'd0;
                    seen_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            WR: begin
                if (addr == ADDR_HI) begin
                    state_d = RD;
                    addr_d  = ADDR_LO;
                end else begin
                    addr_d = addr + 6'd1;
                end
            end
            RD: begin
                if (miss) begin
                    errs_d = errs + 9'd1;
                    if (!seen) begin
                        seen_d    = 1'b1;
                        fe_addr_d = addr;
                        fe_pass_d = pidx;
                    end
                end
                if (addr == ADDR_HI) begin
                    addr_d = ADDR_LO;
                    if (pidx == 2'd3) begin
                        // Include the final compare so pass is valid while done is high.
                        state_d = DONE;
                        pass_d  = (errs_d == 9'd0);
                    end else begin
                        pidx_d  = pidx + 2'd1;
                        state_d = WR;
                    end
                end else begin
                    addr_d = addr + 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy           = (state == WR) || (state == RD);
    assign done           = (state == DONE);
    assign Mem_Write      = (state == WR);
    assign DM_Addr        = busy ? addr : 6'd0;
    assign MW_Data_s      = (state == WR) ? sel : 2'd0;
    assign pass           = pass_q;
    assign err_cnt        = errs;
    assign first_err_addr = fe_addr;
    assign first_err_pass = fe_pass;
    assign state_dbg      = state;

endmodule
